// File: rtl/multiplicador_algoritmico_pkg.sv
// multiplicador_algoritmico_pkg: shared FSM state type and default operand width
package multiplicador_algoritmico_pkg;
  localparam int TAMANYO_DEF = 32;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FIN} estado_t;
endpackage

// File: rtl/multiplicador_algoritmico_abs_val.sv
// abs_val: two's complement operand split into sign bit and unsigned magnitude
module abs_val #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         sign
);
  assign sign = x[W-1];
  assign mag  = sign ? -x : x;
endmodule

// File: rtl/multiplicador_algoritmico.sv
// multiplicador_algoritmico: sequential sign-magnitude shift-and-add multiplier
module multiplicador_algoritmico
  import multiplicador_algoritmico_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Busy,
  output logic                   Done
);
  localparam int CW = $clog2(tamanyo);
  estado_t state, state_nx;
  logic [tamanyo:0] accu, accu_nx;
  logic [tamanyo-1:0] q, q_nx, m, m_nx, mag_a, mag_b;
  logic [CW-1:0] cont, cont_nx;
  logic sign_a, sign_b, sign_a_nx, sign_b_nx, sa, sb;
  logic [2*tamanyo-1:0] mag_p, prod_nx;
  abs_val #(.W(tamanyo)) u_abs_a (.x(A), .mag(mag_a), .sign(sa));
  abs_val #(.W(tamanyo)) u_abs_b (.x(B), .mag(mag_b), .sign(sb));
  assign Busy  = state != IDLE;
  assign mag_p = {accu[tamanyo-1:0], q};
  always_comb begin
    state_nx  = state;
    accu_nx   = accu;
    q_nx      = q;
    m_nx      = m;
    cont_nx   = cont;
    sign_a_nx = sign_a;
    sign_b_nx = sign_b;
    prod_nx   = Prod;
    case (state)
      IDLE: if (Start) begin
        sign_a_nx = sa;
        sign_b_nx = sb;
        m_nx      = mag_a;
        q_nx      = mag_b;
        accu_nx   = '0;
        cont_nx   = CW'(tamanyo - 1);
        state_nx  = ADD;
      end
      ADD: begin
        accu_nx  = q[0] ? accu + {1'b0, m} : accu;
        state_nx = SHIFT;
      end
      SHIFT: begin
        {accu_nx, q_nx} = {accu, q} >> 1;
        cont_nx  = cont - 1'b1;
        state_nx = (cont == '0) ? FIN : ADD;
      end
      FIN: begin
        prod_nx  = (sign_a ^ sign_b) ? -mag_p : mag_p;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state  <= IDLE;
      accu   <= '0;
      q      <= '0;
      m      <= '0;
      cont   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      Prod   <= '0;
      Done   <= 1'b0;
    end else begin
      state  <= state_nx;
      accu   <= accu_nx;
      q      <= q_nx;
      m      <= m_nx;
      cont   <= cont_nx;
      sign_a <= sign_a_nx;
      sign_b <= sign_b_nx;
      Prod   <= prod_nx;
      Done   <= state == FIN;
    end
  end
endmodule
